// File: rtl/rs_station_mc.sv
// Reservation station: holds pending ALU/branch ops, captures CDB results,
// and dispatches one ready op per cycle (oldest-first or lowest-index).
module rs_station_mc #(
  parameter int RS_DEPTH = 16,
  parameter int RS_BW    = 4,
  parameter int ROB_BW   = 4,
  parameter int CDB_N    = 2,
  parameter int DATA_W   = 32,
  parameter int CODE_W   = 6,
  parameter int AGE_PICK = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      rdy,
  input  logic                      flush,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [DATA_W-1:0]         in_V1,
  input  logic [DATA_W-1:0]         in_V2,
  input  logic [ROB_BW-1:0]         in_Q1,
  input  logic [ROB_BW-1:0]         in_Q2,
  input  logic [DATA_W-1:0]         in_A,
  input  logic [CODE_W-1:0]         in_code,
  input  logic [ROB_BW-1:0]         in_rob_id,
  input  logic [DATA_W-1:0]         in_pc,
  input  logic [CDB_N-1:0]          cdb_valid,
  input  logic [CDB_N*ROB_BW-1:0]   cdb_rob_id,
  input  logic [CDB_N*DATA_W-1:0]   cdb_val,
  output logic                      ex_valid,
  input  logic                      ex_ready,
  output logic [DATA_W-1:0]         ex_V1,
  output logic [DATA_W-1:0]         ex_V2,
  output logic [DATA_W-1:0]         ex_A,
  output logic [DATA_W-1:0]         ex_pc,
  output logic [CODE_W-1:0]         ex_code,
  output logic [ROB_BW-1:0]         ex_rob_id,
  output logic [RS_BW:0]            occupancy
);

  logic [RS_DEPTH-1:0] r_busy;
  logic [DATA_W-1:0]   r_v1   [RS_DEPTH];
  logic [DATA_W-1:0]   r_v2   [RS_DEPTH];
  logic [ROB_BW-1:0]   r_q1   [RS_DEPTH];
  logic [ROB_BW-1:0]   r_q2   [RS_DEPTH];
  logic [DATA_W-1:0]   r_a    [RS_DEPTH];
  logic [CODE_W-1:0]   r_code [RS_DEPTH];
  logic [ROB_BW-1:0]   r_rob  [RS_DEPTH];
  logic [DATA_W-1:0]   r_pc   [RS_DEPTH];
  // r_older[j][i] = 1 means entry j was inserted before entry i
  logic [RS_DEPTH-1:0] r_older [RS_DEPTH];
  logic [RS_BW:0]      r_occ;

  logic [RS_DEPTH-1:0] w_rdy;
  logic [RS_DEPTH-1:0] w_cand;
  logic [RS_BW-1:0]    w_free;
  logic [RS_BW-1:0]    w_sel;
  logic                w_load;
  logic                w_ins;

  assign occupancy = r_occ;
  assign in_ready  = rdy && (r_occ != (RS_BW+1)'(RS_DEPTH));
  assign w_ins     = in_valid && in_ready;
  assign w_load    = (!ex_valid || ex_ready) && (|w_rdy);

  function automatic logic cdb_hit(input logic [ROB_BW-1:0] tag);
    cdb_hit = 1'b0;
    for (int c = 0; c < CDB_N; c++)
      if (tag != '0 && cdb_valid[c] &&
          cdb_rob_id[c*ROB_BW +: ROB_BW] == tag)
        cdb_hit = 1'b1;
  endfunction

  // Scan high to low so the lowest matching channel wins
  function automatic logic [DATA_W-1:0] cdb_data(
    input logic [ROB_BW-1:0] tag);
    cdb_data = '0;
    for (int c = CDB_N - 1; c >= 0; c--)
      if (cdb_valid[c] && cdb_rob_id[c*ROB_BW +: ROB_BW] == tag)
        cdb_data = cdb_val[c*DATA_W +: DATA_W];
  endfunction

  always_comb begin
    w_rdy  = '0;
    w_free = '0;
    w_sel  = '0;
    for (int i = 0; i < RS_DEPTH; i++)
      w_rdy[i] = r_busy[i] && r_q1[i] == '0 && r_q2[i] == '0;
    w_cand = w_rdy;
    if (AGE_PICK != 0)
      for (int i = 0; i < RS_DEPTH; i++)
        for (int j = 0; j < RS_DEPTH; j++)
          if (w_rdy[j] && r_older[j][i])
            w_cand[i] = 1'b0;
    for (int i = RS_DEPTH - 1; i >= 0; i--) begin
      if (!r_busy[i]) w_free = RS_BW'(i);
      if (w_cand[i])  w_sel  = RS_BW'(i);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_busy    <= '0;
      r_occ     <= '0;
      ex_valid  <= 1'b0;
      ex_V1     <= '0;
      ex_V2     <= '0;
      ex_A      <= '0;
      ex_pc     <= '0;
      ex_code   <= '0;
      ex_rob_id <= '0;
      for (int i = 0; i < RS_DEPTH; i++)
        r_older[i] <= '0;
    end else if (flush) begin
      r_busy   <= '0;
      r_occ    <= '0;
      ex_valid <= 1'b0;
      for (int i = 0; i < RS_DEPTH; i++)
        r_older[i] <= '0;
    end else if (rdy) begin
      for (int i = 0; i < RS_DEPTH; i++) begin
        if (r_busy[i] && cdb_hit(r_q1[i])) begin
          r_v1[i] <= cdb_data(r_q1[i]);
          r_q1[i] <= '0;
        end
        if (r_busy[i] && cdb_hit(r_q2[i])) begin
          r_v2[i] <= cdb_data(r_q2[i]);
          r_q2[i] <= '0;
        end
      end
      if (w_load) begin
        r_busy[w_sel] <= 1'b0;
        ex_valid      <= 1'b1;
        ex_V1         <= r_v1[w_sel];
        ex_V2         <= r_v2[w_sel];
        ex_A          <= r_a[w_sel];
        ex_pc         <= r_pc[w_sel];
        ex_code       <= r_code[w_sel];
        ex_rob_id     <= r_rob[w_sel];
      end else if (!ex_valid || ex_ready) begin
        ex_valid <= 1'b0;
      end
      if (w_ins) begin
        r_busy[w_free] <= 1'b1;
        r_v1[w_free]   <= cdb_hit(in_Q1) ? cdb_data(in_Q1) : in_V1;
        r_q1[w_free]   <= cdb_hit(in_Q1) ? '0 : in_Q1;
        r_v2[w_free]   <= cdb_hit(in_Q2) ? cdb_data(in_Q2) : in_V2;
        r_q2[w_free]   <= cdb_hit(in_Q2) ? '0 : in_Q2;
        r_a[w_free]    <= in_A;
        r_code[w_free] <= in_code;
        r_rob[w_free]  <= in_rob_id;
        r_pc[w_free]   <= in_pc;
        r_older[w_free] <= '0;
        for (int j = 0; j < RS_DEPTH; j++)
          if (r_busy[j]) r_older[j][w_free] <= 1'b1;
      end
      r_occ <= r_occ + (RS_BW+1)'(w_ins) - (RS_BW+1)'(w_load);
    end
  end

endmodule

// File: tb/tb_rs_station_mc.sv
// Bench for rs_station_mc: directed scenarios plus random traffic,
// all checked against an in-order queue model of the station.
module tb_rs_station_mc;

  localparam int D = 16;

  logic        clk = 1'b0;
  logic        rst, rdy, flush, in_valid, in_ready;
  logic [31:0] in_V1, in_V2, in_A, in_pc;
  logic [3:0]  in_Q1, in_Q2, in_rob_id;
  logic [5:0]  in_code;
  logic [1:0]  cdb_valid;
  logic [7:0]  cdb_rob_id;
  logic [63:0] cdb_val;
  logic        ex_valid, ex_ready;
  logic [31:0] ex_V1, ex_V2, ex_A, ex_pc;
  logic [5:0]  ex_code;
  logic [3:0]  ex_rob_id;
  logic [4:0]  occupancy;

  always #5 clk = ~clk;

  rs_station_mc dut (
    .clk(clk), .rst(rst), .rdy(rdy), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_V1(in_V1), .in_V2(in_V2), .in_Q1(in_Q1), .in_Q2(in_Q2),
    .in_A(in_A), .in_code(in_code), .in_rob_id(in_rob_id),
    .in_pc(in_pc), .cdb_valid(cdb_valid),
    .cdb_rob_id(cdb_rob_id), .cdb_val(cdb_val),
    .ex_valid(ex_valid), .ex_ready(ex_ready),
    .ex_V1(ex_V1), .ex_V2(ex_V2), .ex_A(ex_A), .ex_pc(ex_pc),
    .ex_code(ex_code), .ex_rob_id(ex_rob_id),
    .occupancy(occupancy)
  );

  typedef struct {
    logic [31:0] v1, v2, a, pc;
    logic [3:0]  q1, q2, rob;
    logic [5:0]  code;
  } ent_t;

  ent_t mq[$];
  ent_t mex;
  bit   mexv;
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic void cdb_look(input logic [3:0] t,
                                   output bit hit,
                                   output logic [31:0] v);
    hit = 0;
    v   = '0;
    if (t != 0)
      for (int c = 0; c < 2; c++)
        if (!hit && cdb_valid[c] && cdb_rob_id[c*4 +: 4] == t) begin
          hit = 1;
          v   = cdb_val[c*32 +: 32];
        end
  endfunction

  task automatic step();
    bit          exp_ir, h;
    int          sel;
    ent_t        e;
    logic [31:0] v;
    @(negedge clk);
    exp_ir = rdy && (mq.size() < D);
    chk("in_ready", in_ready, exp_ir);
    if (flush) begin
      mq.delete();
      mexv = 0;
    end else if (rdy) begin
      sel = -1;
      foreach (mq[i])
        if (sel < 0 && mq[i].q1 == 0 && mq[i].q2 == 0) sel = i;
      foreach (mq[i]) begin
        cdb_look(mq[i].q1, h, v);
        if (h) begin mq[i].v1 = v; mq[i].q1 = 0; end
        cdb_look(mq[i].q2, h, v);
        if (h) begin mq[i].v2 = v; mq[i].q2 = 0; end
      end
      if (sel >= 0 && (!mexv || ex_ready)) begin
        mex  = mq[sel];
        mq.delete(sel);
        mexv = 1;
      end else if (!mexv || ex_ready) begin
        mexv = 0;
      end
      if (in_valid && exp_ir) begin
        e.v1 = in_V1; e.q1 = in_Q1; e.v2 = in_V2; e.q2 = in_Q2;
        cdb_look(in_Q1, h, v);
        if (h) begin e.v1 = v; e.q1 = 0; end
        cdb_look(in_Q2, h, v);
        if (h) begin e.v2 = v; e.q2 = 0; end
        e.a = in_A; e.pc = in_pc; e.code = in_code; e.rob = in_rob_id;
        mq.push_back(e);
      end
    end
    @(posedge clk);
    #1;
    chk("ex_valid", ex_valid, mexv);
    chk("occupancy", occupancy, mq.size());
    if (mexv) begin
      chk("ex_V1", ex_V1, mex.v1);
      chk("ex_V2", ex_V2, mex.v2);
      chk("ex_A", ex_A, mex.a);
      chk("ex_pc", ex_pc, mex.pc);
      chk("ex_code", ex_code, mex.code);
      chk("ex_rob_id", ex_rob_id, mex.rob);
    end
  endtask

  task automatic idle();
    rst = 0; rdy = 1; flush = 0; in_valid = 0; ex_ready = 1;
    cdb_valid = '0; cdb_rob_id = '0; cdb_val = '0;
  endtask

  task automatic ins(input logic [31:0] v1, input logic [31:0] v2,
                     input logic [3:0] q1, input logic [3:0] q2,
                     input logic [3:0] rob);
    in_valid = 1; in_V1 = v1; in_V2 = v2; in_Q1 = q1; in_Q2 = q2;
    in_rob_id = rob; in_A = $urandom; in_pc = $urandom;
    in_code = 6'($urandom);
  endtask

  task automatic bcast(input logic [3:0] tag, input logic [31:0] val);
    cdb_valid = 2'b01; cdb_rob_id = {4'd0, tag}; cdb_val = {32'd0, val};
  endtask

  initial begin
    idle();
    ins(0, 0, 0, 0, 0);
    in_valid = 0;
    rst = 1;
    repeat (2) @(posedge clk);
    #1;
    rst = 0;
    mexv = 0;
    chk("rst_ex_valid", ex_valid, 0);
    chk("rst_occ", occupancy, 0);
    chk("rst_ex_V1", ex_V1, 0);
    chk("rst_ex_rob", ex_rob_id, 0);
    chk("rst_in_ready", in_ready, 1);

    // Ready op dispatches one cycle after insert
    idle(); ins(5, 7, 0, 0, 3); step();
    idle(); step();
    chk("t1_V1", ex_V1, 5);
    chk("t1_V2", ex_V2, 7);
    chk("t1_rob", ex_rob_id, 3);
    step();
    chk("t1_occ", occupancy, 0);

    // Same-cycle bypass on insert via channel 1
    idle(); ins(1, 2, 4, 0, 6);
    cdb_valid = 2'b10; cdb_rob_id = {4'd4, 4'd0};
    cdb_val = {32'h55, 32'h0};
    step();
    idle(); step();
    chk("t2_V1", ex_V1, 32'h55);
    step();

    // Younger ready op goes first; woken older op next cycle
    idle(); ins(0, 1, 2, 0, 1); step();
    idle(); ins(3, 4, 0, 0, 2); step();
    idle(); bcast(2, 32'hA0); step();
    chk("t3_first", ex_rob_id, 2);
    idle(); step();
    chk("t3_second", ex_rob_id, 1);
    chk("t3_A_val", ex_V1, 32'hA0);
    step();

    // Both ready behind a stalled stage: older goes first
    idle(); ex_ready = 0; ins(9, 9, 0, 0, 7); step();
    idle(); ex_ready = 0; ins(0, 1, 2, 0, 1); step();
    idle(); ex_ready = 0; ins(3, 4, 0, 0, 2); step();
    idle(); ex_ready = 0; bcast(2, 32'hB0); step();
    idle(); ex_ready = 0; step();
    idle(); step();
    chk("t3_age_first", ex_rob_id, 1);
    idle(); step();
    chk("t3_age_second", ex_rob_id, 2);
    step(); step();

    // Fill, overflow attempt, then a single wakeup drains all
    for (int i = 0; i < D; i++) begin
      idle(); ins(i, i + 100, 9, 0, 4'(i)); step();
    end
    idle();
    chk("t4_full_occ", occupancy, 16);
    chk("t4_full_ir", in_ready, 0);
    ins(77, 77, 0, 0, 15); step();
    chk("t4_ignored_occ", occupancy, 16);
    idle(); bcast(9, 32'hC0); step();
    idle();
    for (int i = 0; i < D; i++) begin
      step();
      chk("t4_stream", ex_valid, 1);
    end
    step();
    chk("t4_empty", occupancy, 0);

    // Backpressure hold then release
    for (int i = 0; i < 3; i++) begin
      idle(); ex_ready = 0; ins(i, i, 0, 0, 4'(10 + i)); step();
    end
    idle(); ex_ready = 0;
    repeat (3) step();
    chk("t5_hold_rob", ex_rob_id, 10);
    chk("t5_hold_occ", occupancy, 2);
    idle(); step();
    chk("t5_next", ex_rob_id, 11);
    step(); step();

    // Flush with busy entries, valid output and concurrent insert
    idle(); ex_ready = 0; ins(1, 1, 0, 0, 5); step();
    for (int i = 0; i < 5; i++) begin
      idle(); ex_ready = 0; ins(i, i, 13, 0, 4'(i)); step();
    end
    idle(); flush = 1; ins(8, 8, 0, 0, 8); step();
    chk("t6_occ", occupancy, 0);
    chk("t6_ex_valid", ex_valid, 0);
    chk("t6_in_ready", in_ready, 1);
    idle(); bcast(13, 32'hD0);
    repeat (4) step();
    chk("t6_no_ghost", ex_valid, 0);

    // Random traffic
    for (int n = 0; n < 1500; n++) begin
      idle();
      rdy      = $urandom_range(0, 9) != 0;
      flush    = $urandom_range(0, 79) == 0;
      ex_ready = $urandom_range(0, 3) != 0;
      if ($urandom_range(0, 9) < 6)
        ins($urandom, $urandom,
            $urandom_range(0, 1) ? 4'd0 : 4'($urandom_range(1, 15)),
            $urandom_range(0, 1) ? 4'd0 : 4'($urandom_range(1, 15)),
            4'($urandom));
      cdb_valid  = 2'($urandom);
      cdb_rob_id = 8'($urandom);
      cdb_val    = {$urandom, $urandom};
      step();
    end
    idle(); flush = 1; step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/rs_station_mc.md
Name: rs_station_mc

Overview:
- Parametrised reservation station for the out-of-order core. Sits between decode/issue and the ALU.
- Holds up to RS_DEPTH pending ALU/branch ops and captures operands from CDB_N broadcast buses, including same-cycle bypass on insert.
- Each cycle it dispatches at most one ready op, oldest-first or lowest-index, over a valid/ready handshake with ALU backpressure.

Parameters:
RS_DEPTH, 16, number of entries (power of 2, >=2)
RS_BW, 4, log2(RS_DEPTH)
ROB_BW, 4, ROB tag width; tag 0 means "operand ready / no producer"
CDB_N, 2, number of CDB channels
DATA_W, 32, operand/immediate/pc width
CODE_W, 6, opcode width
AGE_PICK, 1, 1 = oldest ready entry first (age matrix), 0 = lowest-index ready entry

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
rdy  in  1  global enable; low = freeze all state
flush  in  1  mispredict flush; drops all entries and output
in_valid  in  1  issue request
in_ready  out  1  entry free (combinational from registered state)
in_V1, in_V2  in  DATA_W  operand values
in_Q1, in_Q2  in  ROB_BW  producer tags (0 = ready)
in_A  in  DATA_W  immediate
in_code  in  CODE_W  opcode
in_rob_id  in  ROB_BW  destination ROB tag
in_pc  in  DATA_W  instruction pc
cdb_valid  in  CDB_N  per-channel broadcast valid
cdb_rob_id  in  CDB_N*ROB_BW  channel c at bits [c*ROB_BW +: ROB_BW]
cdb_val  in  CDB_N*DATA_W  channel c at bits [c*DATA_W +: DATA_W]
ex_valid  out  1  dispatch output valid (registered)
ex_ready  in  1  ALU accepts
ex_V1, ex_V2, ex_A, ex_pc  out  DATA_W  dispatched fields (registered)
ex_code  out  CODE_W  dispatched opcode
ex_rob_id  out  ROB_BW  dispatched ROB tag
occupancy  out  RS_BW+1  busy entry count (registered)

Behaviour:
- Reset (rst, priority over all): busy=0, age matrix=0, ex_valid=0, occupancy=0. Other ex_* outputs are 0.
- flush (when not rst): busy=0, age=0, ex_valid=0, occupancy=0. Same-cycle insert and CDB captures are dropped. Acts regardless of rdy.
- rdy=0: no state change; in_ready=0; ex_* outputs hold.
- in_ready = rdy && (occupancy != RS_DEPTH); does not depend on in_valid. A slot freed by dispatch this cycle is usable next cycle.
- Insert when in_valid && in_ready: write the lowest-index free entry.
  - For each operand, if Qx!=0 and a valid CDB channel carries tag Qx this cycle, store that cdb_val and Qx=0 (bypass).
  - Otherwise store in_Vx/in_Qx as given.
- Wakeup: for every busy entry with Qx!=0 matching a valid channel: Vx<=value, Qx<=0.
  - Tag 0 never matches.
  - If several channels match, the lowest channel index wins.
- Ready(i) = busy[i] && Q1[i]==0 && Q2[i]==0, evaluated on registered state. Wakeup takes effect for selection the next cycle.
- Age matrix (AGE_PICK=1): on insert into k, set older[j][k]=1 for every busy j and clear older[k][*].
  - Select the ready i such that no ready j has older[j][i].
  - AGE_PICK=0: select the lowest-index ready i.
- Output stage: load when (!ex_valid || ex_ready) && any ready.
  - Copy the selected entry to ex_*, set ex_valid=1, clear its busy bit.
  - If the stage is free and nothing is ready, ex_valid<=0.
  - If ex_valid && !ex_ready, hold all ex_* and free no entry.
- Latency: entry inserted with both operands ready dispatches with ex_valid high 1 cycle after insert (insert at edge N, ex_valid at edge N+1). Each CDB wakeup adds 1 cycle.
- occupancy <= occupancy + insert - dispatch; a simultaneous insert and dispatch leaves it unchanged.
- Full: in_ready=0. An in_valid without in_ready is ignored (no side effects).

Test Plan:
1. Insert V1=5,V2=7,Q1=Q2=0,rob_id=3 -> next cycle ex_valid=1, ex_V1=5, ex_V2=7, ex_rob_id=3; occupancy returns to 0.
2. Insert Q1=4 while cdb_valid[1]=1, cdb_rob_id ch1=4, val=0x55 -> entry captured ready; ex_V1=0x55 one cycle later.
3. Insert A (Q1=2), then B (ready), then CDB tag 2 with ex_ready=1 (AGE_PICK=1) -> B dispatches first, A next cycle after wakeup. With ex_ready held low, A and B wait and then dispatch A first (older).
4. Fill 16 entries with Q1=9 -> in_ready=0 and occupancy=16; a 17th in_valid is ignored. CDB tag 9 -> 16 dispatches on consecutive cycles with ex_ready=1.
5. ex_ready=0 for 3 cycles with ex_valid=1 -> ex_* stable, occupancy unchanged; release -> next entry follows.
6. flush with 5 busy entries, ex_valid=1 and a concurrent insert -> next cycle occupancy=0, ex_valid=0, in_ready=1; no later dispatch of the dropped ops.
